// File: rtl/pool_layer_sequencer_if.sv
// Handshake and memory-port bundle between pool_layer_sequencer and its neighbours:
// upstream act memory, max_pool and downstream act memory.
interface pool_layer_sequencer_if #(
    parameter int DATA_SIZE = 64
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [47:0]          src_read_index;
    logic [DATA_SIZE-1:0] src_read_data;
    logic [47:0]          pool_write_index;
    logic [DATA_SIZE-1:0] pool_write_data;
    logic                 pool_want_write;
    logic                 pool_compute;
    logic                 pool_output_valid;
    logic [47:0]          pool_read_index;
    logic [DATA_SIZE-1:0] pool_read_data;
    logic [47:0]          dst_write_index;
    logic [DATA_SIZE-1:0] dst_write_data;
    logic                 dst_want_write;

    modport master (
        input  start,
        output busy, done,
        output src_read_index,
        input  src_read_data,
        output pool_write_index, pool_write_data, pool_want_write, pool_compute,
        input  pool_output_valid,
        output pool_read_index,
        input  pool_read_data,
        output dst_write_index, dst_write_data, dst_want_write
    );

    modport slave (
        output start,
        input  busy, done,
        input  src_read_index,
        output src_read_data,
        input  pool_write_index, pool_write_data, pool_want_write, pool_compute,
        output pool_output_valid,
        input  pool_read_index,
        output pool_read_data,
        input  dst_write_index, dst_write_data, dst_want_write
    );
endinterface

// File: rtl/pool_layer_sequencer.sv
// Sequences one max_pool layer per start: load upstream activations, kick compute,
// wait out the pooling pass, then drain pooled results to the downstream memory.
module pool_layer_sequencer #(
    parameter int NUM_INPUTS = 16,
    parameter int INPUT_DIM  = 26,
    parameter int KERNEL_DIM = 2,
    parameter int STRIDE     = KERNEL_DIM,
    parameter int DATA_SIZE  = 64
) (
    input logic                    clk,
    input logic                    rst,
    pool_layer_sequencer_if.master bus
);

    localparam int OUTPUT_DIM = (INPUT_DIM - KERNEL_DIM) / STRIDE + 1;
    localparam logic [31:0] COMPUTE_CYCLES =
        32'(2 * KERNEL_DIM * KERNEL_DIM * NUM_INPUTS * OUTPUT_DIM * OUTPUT_DIM + 2);
    localparam logic [15:0] ENT_LAST = 16'(NUM_INPUTS - 1);
    localparam logic [15:0] IN_LAST  = 16'(INPUT_DIM - 1);
    localparam logic [15:0] OUT_LAST = 16'(OUTPUT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ent_q, ent_d;
    logic [15:0] y_q, y_d;
    logic [15:0] x_q, x_d;
    logic        rd_done_q, rd_done_d;
    logic        wr_pend_q, wr_pend_d;
    logic [47:0] wr_idx_q, wr_idx_d;
    logic        kick_q, kick_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] side_last;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ent_q      <= '0;
            y_q        <= '0;
            x_q        <= '0;
            rd_done_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            kick_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ent_q      <= ent_d;
            y_q        <= y_d;
            x_q        <= x_d;
            rd_done_q  <= rd_done_d;
            wr_pend_q  <= wr_pend_d;
            wr_idx_q   <= wr_idx_d;
            kick_q     <= kick_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign side_last = (state_q == S_DRAIN) ? OUT_LAST : IN_LAST;

    // NOTE: every next-state value gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        y_d        = y_q;
        x_d        = x_q;
        rd_done_d  = rd_done_q;
        wr_pend_d  = 1'b0;
        wr_idx_d   = wr_idx_q;
        kick_d     = kick_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    ent_d     = '0;
                    y_d       = '0;
                    x_d       = '0;
                    rd_done_d = 1'b0;
                    kick_d    = 1'b0;
                end
            end
            S_LOAD, S_DRAIN: begin
                if (!rd_done_q) begin
                    wr_pend_d = 1'b1;
                    wr_idx_d  = {ent_q, y_q, x_q};
                    if (x_q == side_last) begin
                        x_d = '0;
                        if (y_q == side_last) begin
                            y_d = '0;
                            if (ent_q == ENT_LAST) begin
                                ent_d     = '0;
                                rd_done_d = 1'b1;
                            end else begin
                                ent_d = ent_q + 16'd1;
                            end
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                end else begin
                    // All reads issued; this cycle carries only the trailing write.
                    state_d = (state_q == S_LOAD) ? S_KICK : S_DONE;
                    kick_d  = 1'b0;
                end
            end
            S_KICK: begin
                kick_d = 1'b1;
                if (kick_q) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // output_valid may be stale from the previous pass, so the cycle floor gates it.
                if (bus.pool_output_valid && (wait_cnt_q >= COMPUTE_CYCLES)) begin
                    state_d   = S_DRAIN;
                    ent_d     = '0;
                    y_d       = '0;
                    x_d       = '0;
                    rd_done_d = 1'b0;
                end else if (wait_cnt_q != 32'hFFFF_FFFF) begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy             = (state_q != S_IDLE);
    assign bus.done             = (state_q == S_DONE);
    assign bus.pool_compute     = (state_q == S_KICK);
    assign bus.src_read_index   = {ent_q, y_q, x_q};
    assign bus.pool_read_index  = {ent_q, y_q, x_q};
    assign bus.pool_want_write  = (state_q == S_LOAD) && wr_pend_q;
    assign bus.dst_want_write   = (state_q == S_DRAIN) && wr_pend_q;
    assign bus.pool_write_index = wr_idx_q;
    assign bus.dst_write_index  = wr_idx_q;
    assign bus.pool_write_data  = bus.pool_want_write ? bus.src_read_data  : {DATA_SIZE{1'b0}};
    assign bus.dst_write_data   = bus.dst_want_write  ? bus.pool_read_data : {DATA_SIZE{1'b0}};

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Directed bench for pool_layer_sequencer with small memory models and a behavioural max_pool.
module tb_pool_layer_sequencer;

    localparam int N  = 2;
    localparam int ID = 4;
    localparam int KD = 2;
    localparam int DS = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pool_layer_sequencer_if #(.DATA_SIZE(DS)) bus ();

    pool_layer_sequencer #(
        .NUM_INPUTS(N), .INPUT_DIM(ID), .KERNEL_DIM(KD), .STRIDE(KD), .DATA_SIZE(DS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    int  src_mode = 0;
    bit  use_model = 1'b0;
    bit  tb_valid = 1'b0;
    bit  model_valid = 1'b0;
    int  model_cnt = 0;
    real in_mem [0:1][0:3][0:3];
    real out_mem[0:1][0:1][0:1];

    // Upstream memory: value=index, or doubles for the max_pool passes.
    always @(posedge clk) begin
        int  e, y, x;
        real v;
        e = int'(bus.src_read_index[47:32]);
        y = int'(bus.src_read_index[31:16]);
        x = int'(bus.src_read_index[15:0]);
        v = real'(e * 100 + y * 4 + x);
        case (src_mode)
            0:       bus.src_read_data <= {16'h0, bus.src_read_index};
            1:       bus.src_read_data <= $realtobits(v);
            default: bus.src_read_data <= $realtobits(0.5 - v);
        endcase
    end

    // Behavioural max_pool: restarts on compute, never clears output_valid.
    always @(posedge clk) begin
        real m;
        if (bus.pool_want_write)
            in_mem[bus.pool_write_index[32]][bus.pool_write_index[17:16]][bus.pool_write_index[1:0]] =
                $bitstoreal(bus.pool_write_data);
        if (bus.pool_compute) begin
            model_cnt <= 60;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) begin
                for (int e = 0; e < 2; e++)
                    for (int oy = 0; oy < 2; oy++)
                        for (int ox = 0; ox < 2; ox++) begin
                            m = in_mem[e][2*oy][2*ox];
                            for (int dy = 0; dy < 2; dy++)
                                for (int dx = 0; dx < 2; dx++)
                                    if (in_mem[e][2*oy+dy][2*ox+dx] > m) m = in_mem[e][2*oy+dy][2*ox+dx];
                            out_mem[e][oy][ox] = m;
                        end
                model_valid <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (use_model)
            bus.pool_read_data <= $realtobits(
                out_mem[bus.pool_read_index[32]][bus.pool_read_index[16]][bus.pool_read_index[0]]);
        else
            bus.pool_read_data <= 64'hA0 + 64'(bus.pool_read_index[15:0]);
    end

    assign bus.pool_output_valid = use_model ? model_valid : tb_valid;

    // Per-pass observation log.
    logic [47:0] pw_idx[$];
    logic [63:0] pw_dat[$];
    logic [47:0] dw_idx[$];
    logic [63:0] dw_dat[$];
    int   first_pw, last_pw, first_comp, comp_cycles, wait_start, first_dw_rel, done_cnt, done_rel;
    logic busy_after_done, busy_tail;
    bit   timed_out;

    function automatic logic [47:0] idx3(input int e, input int y, input int x);
        return {16'(e), 16'(y), 16'(x)};
    endfunction

    task automatic run_pass(input int valid_at, input bit inject, input int abort_at);
        bit comp_seen = 1'b0;
        int done_cyc  = -1;
        pw_idx.delete(); pw_dat.delete(); dw_idx.delete(); dw_dat.delete();
        first_pw = -1; last_pw = -1; first_comp = -1; comp_cycles = 0; wait_start = -1;
        first_dw_rel = -1; done_cnt = 0; done_rel = -1; busy_after_done = 1'bx; busy_tail = 1'b0;
        timed_out = 1'b0;
        tb_valid = (valid_at == 0);
        @(posedge clk); #1;
        bus.start = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (bus.pool_want_write) begin
                pw_idx.push_back(bus.pool_write_index);
                pw_dat.push_back(bus.pool_write_data);
                if (first_pw < 0) first_pw = cyc;
                last_pw = cyc;
            end
            if (bus.pool_compute) begin
                comp_cycles++;
                if (first_comp < 0) first_comp = cyc;
                comp_seen = 1'b1;
            end else if (comp_seen && wait_start < 0) begin
                wait_start = cyc;
            end
            if (bus.dst_want_write) begin
                dw_idx.push_back(bus.dst_write_index);
                dw_dat.push_back(bus.dst_write_data);
                if (first_dw_rel < 0) first_dw_rel = cyc - wait_start;
                if (dw_idx.size() == abort_at) begin
                    bus.start = 1'b0;
                    return;
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    done_rel = cyc - wait_start;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = bus.busy;
            if (done_cyc >= 0 && cyc > done_cyc + 1) busy_tail = busy_tail | bus.busy;
            if (done_cyc >= 0 && cyc == done_cyc + 4) begin
                bus.start = 1'b0;
                return;
            end
            bus.start = inject && (cyc == 5 ||
                        (wait_start >= 0 && cyc - wait_start >= 10 && cyc - wait_start <= 12));
            if (valid_at > 0 && wait_start >= 0 && cyc - wait_start >= valid_at) tb_valid = 1'b1;
        end
        timed_out = 1'b1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++;
        if ({bus.pool_want_write, bus.dst_want_write, bus.pool_compute} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.pool_want_write, bus.dst_want_write, bus.pool_compute});
        end
        vectors++;
        if (bus.src_read_index !== 48'h0) begin
            miscompares++; $display("FAIL reset_index: got %h want 0", bus.src_read_index);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_load_kick();
        run_pass(0, 1'b0, 0);
        vectors++;
        if (timed_out !== 1'b0) begin miscompares++; $display("FAIL load_timeout: got 1 want 0"); end
        vectors++;
        if (pw_idx.size() !== 32) begin miscompares++; $display("FAIL load_count: got %0d want 32", pw_idx.size()); end
        for (int k = 0; k < 32 && k < pw_idx.size(); k++) begin
            vectors++;
            if (pw_idx[k] !== idx3(k / 16, (k / 4) % 4, k % 4) || pw_dat[k] !== {16'h0, idx3(k / 16, (k / 4) % 4, k % 4)}) begin
                miscompares++;
                $display("FAIL load_write[%0d]: got idx %h data %h want idx/data %h", k, pw_idx[k], pw_dat[k],
                         idx3(k / 16, (k / 4) % 4, k % 4));
            end
        end
        vectors++;
        if (first_pw !== 2 || last_pw !== 33) begin
            miscompares++; $display("FAIL load_window: got %0d..%0d want 2..33", first_pw, last_pw);
        end
        vectors++;
        if (first_comp !== 34 || comp_cycles !== 2) begin
            miscompares++;
            $display("FAIL kick: got start %0d len %0d want start 34 len 2", first_comp, comp_cycles);
        end
    endtask

    task automatic test_wait_gate();
        run_pass(0, 1'b0, 0);
        vectors++;
        if (first_dw_rel !== 68) begin
            miscompares++; $display("FAIL wait_floor: first dst write at wait+%0d want wait+68", first_dw_rel);
        end
        run_pass(80, 1'b0, 0);
        vectors++;
        if (first_dw_rel !== 82) begin
            miscompares++; $display("FAIL wait_valid80: first dst write at wait+%0d want wait+82", first_dw_rel);
        end
        vectors++;
        if (timed_out !== 1'b0) begin miscompares++; $display("FAIL wait_timeout: got 1 want 0"); end
    endtask

    task automatic check_drain(input string tag);
        vectors++;
        if (dw_idx.size() !== 8) begin
            miscompares++; $display("FAIL %s_count: got %0d want 8", tag, dw_idx.size());
        end
        for (int k = 0; k < 8 && k < dw_idx.size(); k++) begin
            vectors++;
            if (dw_idx[k] !== idx3(k / 4, (k / 2) % 2, k % 2) || dw_dat[k] !== 64'hA0 + 64'(k % 2)) begin
                miscompares++;
                $display("FAIL %s_write[%0d]: got idx %h data %h want idx %h data %h", tag, k, dw_idx[k],
                         dw_dat[k], idx3(k / 4, (k / 2) % 2, k % 2), 64'hA0 + 64'(k % 2));
            end
        end
        vectors++;
        if (done_cnt !== 1 || busy_after_done !== 1'b0 || busy_tail !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: got pulses %0d busy_after %b tail %b want 1 0 0", tag, done_cnt,
                     busy_after_done, busy_tail);
        end
    endtask

    task automatic test_drain_done();
        run_pass(0, 1'b0, 0);
        check_drain("drain");
        vectors++;
        if (done_rel !== 76) begin miscompares++; $display("FAIL done_time: got wait+%0d want wait+76", done_rel); end
    endtask

    task automatic test_start_ignored();
        run_pass(0, 1'b1, 0);
        vectors++;
        if (pw_idx.size() !== 32) begin miscompares++; $display("FAIL busy_start_load: got %0d want 32", pw_idx.size()); end
        check_drain("busy_start");
    endtask

    task automatic test_reset_mid_drain();
        run_pass(0, 1'b0, 4);
        vectors++;
        if (bus.dst_want_write !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_point: got wr %b busy %b want 1 1", bus.dst_want_write, bus.busy);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.dst_want_write, bus.pool_compute, bus.done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_outputs: got %b want 0000",
                     {bus.busy, bus.dst_want_write, bus.pool_compute, bus.done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_pass(0, 1'b0, 0);
        vectors++;
        if (pw_idx.size() !== 32) begin miscompares++; $display("FAIL abort_reload: got %0d want 32", pw_idx.size()); end
        check_drain("after_abort");
    endtask

    task automatic test_back_to_back();
        real g1[8] = '{5.0, 7.0, 13.0, 15.0, 105.0, 107.0, 113.0, 115.0};
        real g2[8] = '{0.5, -1.5, -7.5, -9.5, -99.5, -101.5, -107.5, -109.5};
        use_model = 1'b1;
        src_mode  = 1;
        run_pass(0, 1'b0, 0);
        vectors++;
        if (dw_dat.size() !== 8) begin miscompares++; $display("FAIL b2b_first_count: got %0d want 8", dw_dat.size()); end
        for (int k = 0; k < 8 && k < dw_dat.size(); k++) begin
            vectors++;
            if (dw_dat[k] !== $realtobits(g1[k])) begin
                miscompares++; $display("FAIL b2b_first[%0d]: got %f want %f", k, $bitstoreal(dw_dat[k]), g1[k]);
            end
        end
        src_mode = 2;
        run_pass(0, 1'b0, 0);
        vectors++;
        if (dw_dat.size() !== 8 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL b2b_second_count: got %0d writes %0d done want 8 1", dw_dat.size(), done_cnt);
        end
        for (int k = 0; k < 8 && k < dw_dat.size(); k++) begin
            vectors++;
            if (dw_idx[k] !== idx3(k / 4, (k / 2) % 2, k % 2) || dw_dat[k] !== $realtobits(g2[k])) begin
                miscompares++;
                $display("FAIL b2b_second[%0d]: got idx %h val %f want %f", k, dw_idx[k], $bitstoreal(dw_dat[k]), g2[k]);
            end
        end
        use_model = 1'b0;
        src_mode  = 0;
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_load_kick();
        test_wait_gate();
        test_drain_done();
        test_start_ignored();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
